// File: rtl/card_shoe.sv
// ----------------------------------------------------------------------------
// card_shoe
// 52-card shoe for the blackjack game. The deck lives in registers and is
// shuffled in place by Fisher-Yates, with swap candidates taken from a
// free-running 16-bit LFSR. Each accepted draw produces one card together with
// a one-cycle valid pulse, so no card repeats within a shoe. When the last card
// is drawn the shoe either reshuffles itself (AUTO_RESHUFFLE=1) or waits in
// EMPTY until a shuffle is requested.
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_shuffleReq  request a fresh shuffle (level, sampled each cycle)
//   i_entropy     deal-button level; doubles the LFSR step rate while high
//   i_drawReq     request the next card; taken only while o_ready=1
//   o_ready       shoe can accept a draw this cycle
//   o_cardValid   one-cycle pulse, card outputs hold the drawn card
//   o_cardRank    1=Ace .. 10, 11=J, 12=Q, 13=K (held until the next draw)
//   o_cardSuit    0..3 (held until the next draw)
//   o_cardsLeft   undrawn cards, 0..52
//   o_shuffling   high while in INIT or SHUFFLE
//
// State     | meaning
// ----------+--------------------------------------------------------------
// S_INIT    | load the ordered deck into all 52 slots, idx=51
// S_SHUFFLE | one Fisher-Yates swap per accepted LFSR candidate, idx 51..1
// S_READY   | serve cards from deck[ptr] upward
// S_EMPTY   | shoe exhausted, draws ignored until a shuffle request
// ----------------------------------------------------------------------------
module card_shoe #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter bit          AUTO_RESHUFFLE = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_shuffleReq,
  input  logic       i_entropy,
  input  logic       i_drawReq,
  output logic       o_ready,
  output logic       o_cardValid,
  output logic [3:0] o_cardRank,
  output logic [1:0] o_cardSuit,
  output logic [5:0] o_cardsLeft,
  output logic       o_shuffling
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_SHUFFLE = 2'd1,
    S_READY   = 2'd2,
    S_EMPTY   = 2'd3
  } state_t;

  localparam int          NUM_CARDS = 52;
  localparam logic [5:0]  LAST_IDX  = 6'd51;
  localparam logic [5:0]  FULL_SHOE = 6'd52;
  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [15:0] SEED_SAFE = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic [5:0]  r_idx;
  logic [5:0]  r_ptr;
  logic [5:0]  r_cardsLeft;
  logic        r_cardValid;
  logic [3:0]  r_cardRank;
  logic [1:0]  r_cardSuit;
  logic [5:0]  r_deck [NUM_CARDS];

  logic [15:0] w_lfsr_one;
  logic [15:0] w_lfsr_two;
  logic [15:0] w_lfsr_nxt;
  logic [5:0]  w_j;
  logic        w_j_ok;
  logic        w_swap;
  logic        w_last_swap;
  logic        w_ready;
  logic        w_accept;
  logic [5:0]  w_card;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  always_comb begin
    w_lfsr_one  = lfsr_step(r_lfsr);
    w_lfsr_two  = lfsr_step(w_lfsr_one);
    w_lfsr_nxt  = i_entropy ? w_lfsr_two : w_lfsr_one;

    w_j         = r_lfsr[5:0];
    w_j_ok      = (w_j <= r_idx);
    w_swap      = (r_state == S_SHUFFLE) && w_j_ok;
    w_last_swap = w_swap && (r_idx == 6'd1);

    w_ready     = (r_state == S_READY) && (r_cardsLeft != 6'd0);
    // A shuffle request in the same cycle wins over the draw.
    w_accept    = w_ready && i_drawReq && !i_shuffleReq;
    w_card      = r_deck[r_ptr];
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: begin
        w_state_nxt = S_SHUFFLE;
      end
      S_SHUFFLE: begin
        // Shuffle requests are ignored here; the running shuffle completes.
        if (w_last_swap) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (i_shuffleReq) begin
          w_state_nxt = S_INIT;
        end else if (w_accept && (r_cardsLeft == 6'd1)) begin
          w_state_nxt = AUTO_RESHUFFLE ? S_INIT : S_EMPTY;
        end
      end
      S_EMPTY: begin
        if (i_shuffleReq) begin
          w_state_nxt = S_INIT;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // LFSR, shuffle index, draw pointer, card outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lfsr      <= SEED_SAFE;
      r_idx       <= LAST_IDX;
      r_ptr       <= 6'd0;
      r_cardsLeft <= 6'd0;
      r_cardValid <= 1'b0;
      r_cardRank  <= 4'd0;
      r_cardSuit  <= 2'd0;
    end else begin
      r_lfsr      <= w_lfsr_nxt;
      r_cardValid <= w_accept;

      case (r_state)
        S_INIT: begin
          r_idx       <= LAST_IDX;
          r_ptr       <= 6'd0;
          r_cardsLeft <= 6'd0;
        end
        S_SHUFFLE: begin
          if (w_swap) begin
            r_idx <= r_idx - 6'd1;
          end
          if (w_last_swap) begin
            r_ptr       <= 6'd0;
            r_cardsLeft <= FULL_SHOE;
          end
        end
        S_READY: begin
          if (w_accept) begin
            r_cardSuit  <= w_card[5:4];
            r_cardRank  <= w_card[3:0];
            r_ptr       <= r_ptr + 6'd1;
            r_cardsLeft <= r_cardsLeft - 6'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Deck storage: parallel load in INIT, one swap per accepted candidate.
  // When j == idx both branches pick the same slot, which rewrites itself.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_CARDS; k++) begin
        r_deck[k] <= 6'd0;
      end
    end else if (r_state == S_INIT) begin
      for (int k = 0; k < NUM_CARDS; k++) begin
        r_deck[k] <= {2'(k / 13), 4'((k % 13) + 1)};
      end
    end else if (w_swap) begin
      for (int k = 0; k < NUM_CARDS; k++) begin
        if (6'(k) == r_idx) begin
          r_deck[k] <= r_deck[w_j];
        end else if (6'(k) == w_j) begin
          r_deck[k] <= r_deck[r_idx];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_ready     = w_ready;
  assign o_cardValid = r_cardValid;
  assign o_cardRank  = r_cardRank;
  assign o_cardSuit  = r_cardSuit;
  assign o_cardsLeft = r_cardsLeft;
  assign o_shuffling = (r_state == S_INIT) || (r_state == S_SHUFFLE);

endmodule
